// File: rtl/vend_arbiter.sv
// Round-robin arbiter sharing one dispenser among NREQ vending panels.
// Define VEND_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT cycles.
module vend_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64,
   localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] prod,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   err,
   output logic              disp_start,
   output logic [1:0]        disp_prod,
   input  logic              disp_done,
   output logic              busy,
   output logic [GW-1:0]     grant_id
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] DONE  = 3'd3;
   localparam logic [2:0] ERR   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [GW-1:0] rr_q, rr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [1:0]    prod_q, prod_d;
   logic [1:0]    prod_arr [NREQ];

`ifdef VEND_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   // Cleared while in START so it reads zero on the first WAIT cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == START)
         cnt_d = '0;
      else if (state_q == WAIT)
         cnt_d = cnt_q + CW'(1);
   end
`else
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT != 0);
`endif

   always_comb begin
      for (int i = 0; i < NREQ; i++)
         prod_arr[i] = prod[2*i +: 2];
   end

   always_comb begin
      logic          found;
      logic [GW-1:0] sel;
      int            idx;
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      prod_d  = prod_q;
      found   = 1'b0;
      sel     = '0;
      idx     = 0;
      case (state_q)
         IDLE: begin
            // Scan from rr_q upward, wrapping, and take the first requester.
            for (int i = 0; i < NREQ; i++) begin
               idx = int'(rr_q) + i;
               if (idx >= NREQ)
                  idx = idx - NREQ;
               sel = GW'(idx);
               if (!found && req[sel]) begin
                  found   = 1'b1;
                  grant_d = sel;
                  prod_d  = prod_arr[sel];
               end
            end
            if (found)
               state_d = START;
         end
         START: state_d = prod_q[0] ? WAIT : ERR;
         WAIT: begin
            if (disp_done)
               state_d = DONE;
`ifdef VEND_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1))
               state_d = ERR;
`endif
         end
         DONE, ERR: begin
            state_d = IDLE;
            rr_d    = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         prod_q  <= '0;
`ifdef VEND_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         prod_q  <= prod_d;
`ifdef VEND_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      ack = '0;
      err = '0;
      if (state_q == DONE)
         ack[grant_q] = 1'b1;
      if (state_q == ERR)
         err[grant_q] = 1'b1;
   end

   assign disp_start = (state_q == START) && prod_q[0];
   assign disp_prod  = prod_q;
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Randomized scoreboard bench for vend_arbiter with a transaction-level reference model.
module tb_vend_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] prod;
   logic [3:0] ack;
   logic [3:0] err;
   logic       disp_start;
   logic [1:0] disp_prod;
   logic       disp_done;
   logic       busy;
   logic [1:0] grant_id;

   vend_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .prod       (prod),
      .ack        (ack),
      .err        (err),
      .disp_start (disp_start),
      .disp_prod  (disp_prod),
      .disp_done  (disp_done),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int rr_m   = 0;

   // start entries: {grant, code}; completion entries: {is_err, grant, code}
   logic [3:0] sq_start [$];
   logic [4:0] sq_done  [$];
   logic [3:0] es;
   logic [4:0] ed;
   logic [3:0] ea, ee;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] rv, input int rr);
      for (int i = 0; i < NREQ; i++) begin
         if (rv[(rr + i) % NREQ])
            return (rr + i) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic is_valid(input logic [1:0] code);
      return (code == 2'b01) || (code == 2'b11);
   endfunction

   // Monitor: pops expectations whenever the DUT presents a start or a completion.
   always @(negedge clk) begin
      if (disp_start === 1'b1) begin
         if (sq_start.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_start: disp_start=1, expected no start at %0t", $time);
         end else begin
            es = sq_start.pop_front();
            chk("start_grant", 32'(grant_id), 32'(es[3:2]));
            chk("start_prod", 32'(disp_prod), 32'(es[1:0]));
         end
      end
      if ((|ack) || (|err)) begin
         if (sq_done.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: ack=%b err=%b, expected none at %0t", ack, err, $time);
         end else begin
            ed = sq_done.pop_front();
            ea = ed[4] ? 4'b0000 : (4'b0001 << ed[3:2]);
            ee = ed[4] ? (4'b0001 << ed[3:2]) : 4'b0000;
            chk("done_ack", 32'(ack), 32'(ea));
            chk("done_err", 32'(err), 32'(ee));
            chk("done_prod_held", 32'(disp_prod), 32'(ed[1:0]));
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic do_txn(input logic [3:0] rv, input logic [7:0] pv, input int delay);
      int         g;
      int         k;
      int         n;
      logic [1:0] code;
      logic       vld;
      logic       exp_err;
      logic       bad;
      g       = pick(rv, rr_m);
      code    = pv[2*g +: 2];
      vld     = is_valid(code);
      exp_err = !vld;
`ifdef VEND_ARB_TIMEOUT_EN
      if (vld && (delay < 0 || delay >= TIMEOUT))
         exp_err = 1'b1;
`endif
      if (vld)
         sq_start.push_back({g[1:0], code});
      sq_done.push_back({exp_err, g[1:0], code});
      rr_m = (g + 1) % NREQ;
      req  = rv;
      prod = pv;
      k    = 0;
      @(negedge clk);
      chk("start_latency", 32'(disp_start), 32'(vld));
      chk("busy_in_service", 32'(busy), 32'd1);
      if (vld) begin
         @(negedge clk);
         req  = 4'($urandom);
         prod = 8'($urandom);
         if (delay >= 0) begin
            repeat (delay) begin
               @(negedge clk);
               k++;
            end
            disp_done = 1'b1;
            @(negedge clk);
            disp_done = 1'b0;
         end else begin
`ifndef VEND_ARB_TIMEOUT_EN
            bad = 1'b0;
            repeat (200) begin
               @(negedge clk);
               if (busy !== 1'b1 || (|ack) || (|err))
                  bad = 1'b1;
            end
            chk("wait_holds_without_done", 32'(bad), 32'd0);
            disp_done = 1'b1;
            @(negedge clk);
            disp_done = 1'b0;
`endif
         end
      end
      n = 0;
      while (!((|ack) || (|err)) && n < 2000) begin
         @(negedge clk);
         n++;
         k++;
      end
      chk("completion_seen", 32'(n < 2000), 32'd1);
`ifdef VEND_ARB_TIMEOUT_EN
      if (vld && exp_err)
         chk("timeout_cycles", 32'(k), 32'(TIMEOUT));
`endif
      @(negedge clk);
      req = '0;
      chk("busy_after", 32'(busy), 32'd0);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_start"}, 32'(disp_start), 32'd0);
      chk({tag, "_prod"}, 32'(disp_prod), 32'd0);
      chk({tag, "_grant"}, 32'(grant_id), 32'd0);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      rr_m = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] rv;
      logic [7:0] pv;
      rst       = 1'b0;
      req       = 4'b1111;
      prod      = 8'hFF;
      disp_done = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst = 1'b1;
      req = '0;
      @(negedge clk);

      do_txn(4'b0001, {6'($urandom), 2'b01}, 5);

      pulse_reset();
      for (int i = 0; i < 5; i++)
         do_txn(4'b1111, 8'hFF, int'($urandom_range(0, 3)));

      do_txn(4'b0100, {2'b11, 2'b10, 4'b1111}, 0);
      do_txn(4'b1001, 8'b1101_0011, 1);

      // Done pulse while idle, then a service where prod/req change mid-WAIT.
      disp_done = 1'b1;
      @(negedge clk);
      disp_done = 1'b0;
      @(negedge clk);
      chk("idle_done_ignored", 32'(busy), 32'd0);
      do_txn(4'b0010, 8'b0000_0100, 4);

      // Reset in WAIT aborts silently, then a later request is served.
      rv = 4'b0010;
      pv = 8'b0000_1100;
      sq_start.push_back({2'(pick(rv, rr_m)), 2'b11});
      req  = rv;
      prod = pv;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_quiet("midreset");
      rr_m = 0;
      req  = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      disp_done = 1'b1;
      @(negedge clk);
      disp_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("after_midreset_idle", 32'(busy), 32'd0);
      do_txn(4'b0010, 8'b0000_1100, 2);

      do_txn(4'b1000, 8'b0100_0000, -1);
`ifdef VEND_ARB_TIMEOUT_EN
      do_txn(4'b0001, 8'b0000_0011, TIMEOUT - 1);
`endif

      for (int i = 0; i < 40; i++) begin
         rv = 4'($urandom_range(1, 15));
         pv = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            disp_done = 1'b1;
            @(negedge clk);
            disp_done = 1'b0;
         end
         do_txn(rv, pv, int'($urandom_range(0, 6)));
      end

      repeat (3) @(negedge clk);
      chk("start_queue_drained", 32'(sq_start.size()), 32'd0);
      chk("done_queue_drained", 32'(sq_done.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
